bus_dest_regbank: RTL and testbench
===================================

// Module: bus_dest_regbank
// PURPOSE
//  Destination side of the 32-bit datapath bus: captures the bus value into the register selected
//  by a 5-bit destination code. The encoding is identical to the bus source-select encoding.
//  Holds R0-R15, HI, LO, ZHI, ZLO, PC, MDR, OUTPORT, INPORT, Y and C. Their outputs feed the
//  bus source multiplexer and the ALU. Also provides PC increment, the 64-bit Z load path,
//  the input-port strobe, and sticky illegal-write detection.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value after reset
//  PC_STEP    32'd1          increment applied on pc_inc
//  CNT_W      16             width of the write counter
// PORTS
//  clock      in   1      rising-edge clock
//  clear      in   1      synchronous, active-high reset
//  bus_in     in   32     datapath bus value
//  dst_sel    in   5      destination code (same map as the bus source select)
//  load       in   1      capture bus_in into the register named by dst_sel this edge
//  z_in       in   64     ALU result; [63:32] goes to ZHI, [31:0] goes to ZLO
//  zin        in   1      load z_in into ZHI/ZLO this edge
//  pc_inc     in   1      PC <= PC + PC_STEP this edge
//  in_data    in   32     external input-port data
//  in_strobe  in   1      INPORT <= in_data this edge
//  ba_out     in   1      forces r0 output to 0 (base-address mode)
//  err_clr    in   1      clears wr_err
//  r0..r15    out  32 ea  general-purpose registers; r0 reads 0 while ba_out=1
//  hi,lo,zhi,zlo,pc,mdr,outport,inport,yreg,creg  out 32 ea  special registers
//  wr_err     out  1      sticky flag: an illegal bus write was attempted
//  last_dst   out  5      code of the most recent successful bus write
//  wr_count   out  CNT_W  count of successful bus writes; wraps
// BEHAVIOUR
//  Reset: when clear=1 at an edge, all registers are set to 0, except pc <= RESET_PC.
//   wr_err, last_dst and wr_count are also set to 0. clear overrides every other input.
//  Code map: 00000-01111 = R0-R15; 10000 = HI; 10001 = LO; 10010 = ZHI; 10011 = ZLO;
//   10100 = PC; 10101 = MDR; 10110 = OUTPORT; 10111 = INPORT; 11000 = Y; 11001 = C.
//  Legal bus write: load=1 and dst_sel is in {00000-10001, 10100-10110, 11000, 11001}.
//   The selected register <= bus_in. last_dst <= dst_sel. wr_count <= wr_count + 1 (mod 2^CNT_W).
//   Exactly one register changes.
//  Illegal bus write: load=1 and dst_sel is in {10010, 10011, 10111, 11010-11111}.
//   No register changes. wr_err <= 1. last_dst and wr_count hold.
//  Latency: one edge. The new value is visible on the output immediately after the capturing edge.
//   No bypass: bus_in is never combinationally visible on an output.
//  zin=1: zhi <= z_in[63:32] and zlo <= z_in[31:0]. Independent of load.
//  in_strobe=1: inport <= in_data. Independent of load.
//  pc_inc=1: pc <= pc + PC_STEP, 32-bit wrap-around (32'hFFFF_FFFF + 1 -> 0).
//  Simultaneous events:
//   - load to PC together with pc_inc: the bus value wins; no increment.
//   - err_clr=1 together with an illegal write: wr_err stays 1 (set wins).
//   - err_clr=1 alone: wr_err <= 0 at the edge.
//   - load=0: dst_sel is don't-care; no error and no count.
//  r0 output is combinational: ba_out ? 32'h0 : R0. The stored R0 is never altered by ba_out.
//  No FSM. All state is registered. The only outputs that are combinational from inputs are
//   r0 (through ba_out).
// TESTING
//  1. clear=1 for 1 cycle -> every register output is 0, pc = RESET_PC, wr_err=0, wr_count=0.
//  2. bus_in=32'hDEAD_BEEF, dst_sel=5'b00101, load=1 for 1 cycle -> r5=DEADBEEF next cycle;
//     all other registers are unchanged; last_dst=5'b00101; wr_count=1.
//  3. pc=32'hFFFF_FFFF: pc_inc=1 -> pc=0. Then load to 10100 with bus_in=32'h40 and pc_inc=1
//     together -> pc=32'h40.
//  4. load=1 with dst_sel=5'b10011 -> zlo unchanged, wr_err=1, wr_count unchanged.
//     Then load with dst_sel=11011 and err_clr=1 together -> wr_err stays 1.
//     Then err_clr=1 alone -> wr_err=0.
//  5. zin=1 with z_in=64'h0000_0001_8000_0000 and in_strobe=1 with in_data=7, in one edge ->
//     zhi=1, zlo=32'h8000_0000, inport=7.
//  6. R0 loaded with 32'h55 and ba_out=1 -> r0 output is 0. ba_out=0 -> r0 output is 32'h55.
//     Then clear asserted during a load -> all registers are 0 and the load is lost.

Source files
------------

// File: rtl/bus_dest_regbank.sv
// Destination side of the 32-bit datapath bus.
// Captures bus_in into the register named by dst_sel (same code map as the
// bus source select). It also carries the PC incrementer, the 64-bit Z load
// path, the input-port strobe, and a sticky flag for illegal bus writes.
module bus_dest_regbank #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1,
  parameter int          CNT_W    = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      bus_in,
  input  logic [4:0]       dst_sel,
  input  logic             load,
  input  logic [63:0]      z_in,
  input  logic             zin,
  input  logic             pc_inc,
  input  logic [31:0]      in_data,
  input  logic             in_strobe,
  input  logic             ba_out,
  input  logic             err_clr,
  output logic [31:0]      r0,
  output logic [31:0]      r1,
  output logic [31:0]      r2,
  output logic [31:0]      r3,
  output logic [31:0]      r4,
  output logic [31:0]      r5,
  output logic [31:0]      r6,
  output logic [31:0]      r7,
  output logic [31:0]      r8,
  output logic [31:0]      r9,
  output logic [31:0]      r10,
  output logic [31:0]      r11,
  output logic [31:0]      r12,
  output logic [31:0]      r13,
  output logic [31:0]      r14,
  output logic [31:0]      r15,
  output logic [31:0]      hi,
  output logic [31:0]      lo,
  output logic [31:0]      zhi,
  output logic [31:0]      zlo,
  output logic [31:0]      pc,
  output logic [31:0]      mdr,
  output logic [31:0]      outport,
  output logic [31:0]      inport,
  output logic [31:0]      yreg,
  output logic [31:0]      creg,
  output logic             wr_err,
  output logic [4:0]       last_dst,
  output logic [CNT_W-1:0] wr_count
);

  // Low nibble of the special-register codes (upper bit of dst_sel set).
  // ZHI, ZLO and INPORT have no bus write path and fall to the illegal arm.
  localparam logic [3:0] SP_HI      = 4'h0;
  localparam logic [3:0] SP_LO      = 4'h1;
  localparam logic [3:0] SP_PC      = 4'h4;
  localparam logic [3:0] SP_MDR     = 4'h5;
  localparam logic [3:0] SP_OUTPORT = 4'h6;
  localparam logic [3:0] SP_Y       = 4'h8;
  localparam logic [3:0] SP_C       = 4'h9;

  logic [31:0] gpr [16];
  logic [15:0] gpr_we;
  logic        hi_we, lo_we, pc_we, mdr_we, outport_we, y_we, c_we;
  logic        wr_legal, wr_illegal;

  // Decode a bus write into one-hot write enables and a legal/illegal class.
  always_comb begin
    gpr_we     = '0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    pc_we      = 1'b0;
    mdr_we     = 1'b0;
    outport_we = 1'b0;
    y_we       = 1'b0;
    c_we       = 1'b0;
    wr_legal   = 1'b0;
    wr_illegal = 1'b0;
    if (load) begin
      if (!dst_sel[4]) begin
        gpr_we[dst_sel[3:0]] = 1'b1;
        wr_legal             = 1'b1;
      end else begin
        case (dst_sel[3:0])
          SP_HI:      begin hi_we      = 1'b1; wr_legal = 1'b1; end
          SP_LO:      begin lo_we      = 1'b1; wr_legal = 1'b1; end
          SP_PC:      begin pc_we      = 1'b1; wr_legal = 1'b1; end
          SP_MDR:     begin mdr_we     = 1'b1; wr_legal = 1'b1; end
          SP_OUTPORT: begin outport_we = 1'b1; wr_legal = 1'b1; end
          SP_Y:       begin y_we       = 1'b1; wr_legal = 1'b1; end
          SP_C:       begin c_we       = 1'b1; wr_legal = 1'b1; end
          default:    wr_illegal = 1'b1;
        endcase
      end
    end
  end

  // General-purpose registers R0-R15, written only from the bus.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 16; i++) begin
      if (clear) begin
        gpr[i] <= '0;
      end else if (gpr_we[i]) begin
        gpr[i] <= bus_in;
      end
    end
  end

  // Bus-written special registers: HI, LO, MDR, OUTPORT, Y, C.
  always_ff @(posedge clock) begin
    if (clear) begin
      hi      <= '0;
      lo      <= '0;
      mdr     <= '0;
      outport <= '0;
      yreg    <= '0;
      creg    <= '0;
    end else begin
      if (hi_we)      hi      <= bus_in;
      if (lo_we)      lo      <= bus_in;
      if (mdr_we)     mdr     <= bus_in;
      if (outport_we) outport <= bus_in;
      if (y_we)       yreg    <= bus_in;
      if (c_we)       creg    <= bus_in;
    end
  end

  // PC: a bus load takes priority over the increment in the same edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      pc <= RESET_PC;
    end else if (pc_we) begin
      pc <= bus_in;
    end else if (pc_inc) begin
      pc <= pc + PC_STEP;
    end
  end

  // Z halves and the input port are loaded only from their dedicated paths.
  always_ff @(posedge clock) begin
    if (clear) begin
      zhi    <= '0;
      zlo    <= '0;
      inport <= '0;
    end else begin
      if (zin) begin
        zhi <= z_in[63:32];
        zlo <= z_in[31:0];
      end
      if (in_strobe) inport <= in_data;
    end
  end

  // Write bookkeeping: sticky error (set beats clear), last code, wrap counter.
  always_ff @(posedge clock) begin
    if (clear) begin
      wr_err   <= 1'b0;
      last_dst <= '0;
      wr_count <= '0;
    end else begin
      if (wr_illegal) begin
        wr_err <= 1'b1;
      end else if (err_clr) begin
        wr_err <= 1'b0;
      end
      if (wr_legal) begin
        last_dst <= dst_sel;
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

  // R0 reads as zero in base-address mode; the stored value is untouched.
  assign r0  = ba_out ? 32'h0 : gpr[0];
  assign r1  = gpr[1];
  assign r2  = gpr[2];
  assign r3  = gpr[3];
  assign r4  = gpr[4];
  assign r5  = gpr[5];
  assign r6  = gpr[6];
  assign r7  = gpr[7];
  assign r8  = gpr[8];
  assign r9  = gpr[9];
  assign r10 = gpr[10];
  assign r11 = gpr[11];
  assign r12 = gpr[12];
  assign r13 = gpr[13];
  assign r14 = gpr[14];
  assign r15 = gpr[15];

endmodule

// File: tb/tb_bus_dest_regbank.sv
// Directed bench for bus_dest_regbank: reset, bus writes, PC wrap and
// priority, illegal-write flag, Z/inport paths, base-address R0, and
// write-counter wrap (with a narrowed counter).
module tb_bus_dest_regbank;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] PC_STEP  = 32'd1;
  localparam int          CNT_W    = 4;

  logic             clock = 1'b0;
  logic             clear = 1'b0;
  logic [31:0]      bus_in = '0;
  logic [4:0]       dst_sel = '0;
  logic             load = 1'b0;
  logic [63:0]      z_in = '0;
  logic             zin = 1'b0;
  logic             pc_inc = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_strobe = 1'b0;
  logic             ba_out = 1'b0;
  logic             err_clr = 1'b0;
  logic [31:0]      r0, r1, r2, r3, r4, r5, r6, r7;
  logic [31:0]      r8, r9, r10, r11, r12, r13, r14, r15;
  logic [31:0]      hi, lo, zhi, zlo, pc, mdr, outport, inport, yreg, creg;
  logic             wr_err;
  logic [4:0]       last_dst;
  logic [CNT_W-1:0] wr_count;

  logic [31:0] gpr_obs [16];
  int total = 0;
  int bad   = 0;

  assign gpr_obs[0]  = r0;
  assign gpr_obs[1]  = r1;
  assign gpr_obs[2]  = r2;
  assign gpr_obs[3]  = r3;
  assign gpr_obs[4]  = r4;
  assign gpr_obs[5]  = r5;
  assign gpr_obs[6]  = r6;
  assign gpr_obs[7]  = r7;
  assign gpr_obs[8]  = r8;
  assign gpr_obs[9]  = r9;
  assign gpr_obs[10] = r10;
  assign gpr_obs[11] = r11;
  assign gpr_obs[12] = r12;
  assign gpr_obs[13] = r13;
  assign gpr_obs[14] = r14;
  assign gpr_obs[15] = r15;

  always #5 clock = ~clock;

  bus_dest_regbank #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP),
    .CNT_W    (CNT_W)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .bus_in    (bus_in),
    .dst_sel   (dst_sel),
    .load      (load),
    .z_in      (z_in),
    .zin       (zin),
    .pc_inc    (pc_inc),
    .in_data   (in_data),
    .in_strobe (in_strobe),
    .ba_out    (ba_out),
    .err_clr   (err_clr),
    .r0        (r0),
    .r1        (r1),
    .r2        (r2),
    .r3        (r3),
    .r4        (r4),
    .r5        (r5),
    .r6        (r6),
    .r7        (r7),
    .r8        (r8),
    .r9        (r9),
    .r10       (r10),
    .r11       (r11),
    .r12       (r12),
    .r13       (r13),
    .r14       (r14),
    .r15       (r15),
    .hi        (hi),
    .lo        (lo),
    .zhi       (zhi),
    .zlo       (zlo),
    .pc        (pc),
    .mdr       (mdr),
    .outport   (outport),
    .inport    (inport),
    .yreg      (yreg),
    .creg      (creg),
    .wr_err    (wr_err),
    .last_dst  (last_dst),
    .wr_count  (wr_count)
  );

  // Drive one bus write (or idle) for a single edge; side strobes are set by
  // the caller beforehand and dropped after the edge. Sampling is #1 later.
  task automatic applyStimulus(input logic ld, input logic [4:0] sel, input logic [31:0] val);
    load    = ld;
    dst_sel = sel;
    bus_in  = val;
    @(posedge clock);
    #1;
    load      = 1'b0;
    zin       = 1'b0;
    in_strobe = 1'b0;
    pc_inc    = 1'b0;
    err_clr   = 1'b0;
    clear     = 1'b0;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Directed sequence of steps.
  initial begin
    $display("[TB] start");

    // Reset
    clear = 1'b1;
    applyStimulus(1'b1, 5'd7, 32'h1234_5678);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("rst_r%0d", i), gpr_obs[i], 32'h0);
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_hi", hi, 32'h0);
    checkOutput("rst_wr_err", {31'b0, wr_err}, 32'h0);
    checkOutput("rst_wr_count", {28'b0, wr_count}, 32'h0);
    checkOutput("rst_last_dst", {27'b0, last_dst}, 32'h0);

    // Single write to R5
    applyStimulus(1'b1, 5'b00101, 32'hDEAD_BEEF);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("w5_r%0d", i), gpr_obs[i], (i == 5) ? 32'hDEAD_BEEF : 32'h0);
    checkOutput("w5_pc", pc, RESET_PC);
    checkOutput("w5_last_dst", {27'b0, last_dst}, 32'd5);
    checkOutput("w5_wr_count", {28'b0, wr_count}, 32'd1);

    // PC wrap and bus-over-increment priority
    applyStimulus(1'b1, 5'b10100, 32'hFFFF_FFFF);
    checkOutput("pc_load", pc, 32'hFFFF_FFFF);
    checkOutput("pc_load_cnt", {28'b0, wr_count}, 32'd2);
    pc_inc = 1'b1;
    applyStimulus(1'b0, 5'b10100, 32'h0);
    checkOutput("pc_wrap", pc, 32'h0);
    checkOutput("pc_wrap_cnt", {28'b0, wr_count}, 32'd2);
    pc_inc = 1'b1;
    applyStimulus(1'b1, 5'b10100, 32'h40);
    checkOutput("pc_bus_wins", pc, 32'h40);
    checkOutput("pc_bus_cnt", {28'b0, wr_count}, 32'd3);
    pc_inc = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0);
    checkOutput("pc_inc", pc, 32'h41);

    // Illegal writes and the sticky error flag
    applyStimulus(1'b1, 5'b10011, 32'hAAAA_AAAA);
    checkOutput("ill_zlo", zlo, 32'h0);
    checkOutput("ill_err", {31'b0, wr_err}, 32'h1);
    checkOutput("ill_cnt", {28'b0, wr_count}, 32'd3);
    checkOutput("ill_last", {27'b0, last_dst}, 32'd20);
    err_clr = 1'b1;
    applyStimulus(1'b1, 5'b11011, 32'h1);
    checkOutput("ill_set_wins", {31'b0, wr_err}, 32'h1);
    err_clr = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0);
    checkOutput("err_clr", {31'b0, wr_err}, 32'h0);
    applyStimulus(1'b1, 5'b10111, 32'h9);
    checkOutput("ill_inport", inport, 32'h0);
    checkOutput("ill_inport_err", {31'b0, wr_err}, 32'h1);
    err_clr = 1'b1;
    applyStimulus(1'b0, 5'b11111, 32'h3);
    checkOutput("noload_err", {31'b0, wr_err}, 32'h0);
    checkOutput("noload_cnt", {28'b0, wr_count}, 32'd3);

    // Z and input-port paths in one edge
    zin       = 1'b1;
    z_in      = 64'h0000_0001_8000_0000;
    in_strobe = 1'b1;
    in_data   = 32'd7;
    applyStimulus(1'b0, 5'd0, 32'h0);
    checkOutput("z_hi", zhi, 32'h1);
    checkOutput("z_lo", zlo, 32'h8000_0000);
    checkOutput("inport", inport, 32'h7);
    checkOutput("z_cnt", {28'b0, wr_count}, 32'd3);

    // Remaining bus-writable specials
    applyStimulus(1'b1, 5'b10000, 32'h11);
    applyStimulus(1'b1, 5'b10001, 32'h22);
    applyStimulus(1'b1, 5'b10101, 32'h33);
    applyStimulus(1'b1, 5'b10110, 32'h44);
    applyStimulus(1'b1, 5'b11000, 32'h55);
    applyStimulus(1'b1, 5'b11001, 32'h66);
    applyStimulus(1'b1, 5'b01111, 32'h77);
    checkOutput("sp_hi", hi, 32'h11);
    checkOutput("sp_lo", lo, 32'h22);
    checkOutput("sp_mdr", mdr, 32'h33);
    checkOutput("sp_outport", outport, 32'h44);
    checkOutput("sp_y", yreg, 32'h55);
    checkOutput("sp_c", creg, 32'h66);
    checkOutput("sp_r15", r15, 32'h77);
    checkOutput("sp_r5_kept", r5, 32'hDEAD_BEEF);
    checkOutput("sp_pc_kept", pc, 32'h41);
    checkOutput("sp_last", {27'b0, last_dst}, 32'd15);
    checkOutput("sp_cnt", {28'b0, wr_count}, 32'd10);

    // Base-address mode on R0
    applyStimulus(1'b1, 5'b00000, 32'h55);
    ba_out = 1'b1;
    #1;
    checkOutput("ba_r0_zero", r0, 32'h0);
    ba_out = 1'b0;
    #1;
    checkOutput("ba_r0_val", r0, 32'h55);

    // Clear during a load loses the load
    clear = 1'b1;
    applyStimulus(1'b1, 5'b00011, 32'h99);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("clr_r%0d", i), gpr_obs[i], 32'h0);
    checkOutput("clr_pc", pc, RESET_PC);
    checkOutput("clr_zhi", zhi, 32'h0);
    checkOutput("clr_inport", inport, 32'h0);
    checkOutput("clr_creg", creg, 32'h0);
    checkOutput("clr_cnt", {28'b0, wr_count}, 32'd0);
    checkOutput("clr_last", {27'b0, last_dst}, 32'd0);

    // Counter wrap: 16 writes return a 4-bit counter to zero
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 5'd1, 32'(i));
    checkOutput("wrap_cnt", {28'b0, wr_count}, 32'd0);
    checkOutput("wrap_r1", r1, 32'd15);
    applyStimulus(1'b1, 5'd2, 32'hC0DE);
    checkOutput("wrap_cnt_1", {28'b0, wr_count}, 32'd1);
    checkOutput("wrap_last", {27'b0, last_dst}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
